// File: rtl/baud_tick_gen_frac.sv
`timescale 1ns/1ps
// Fractional baud tick generator: oversample tick plus bit tick from a runtime
// integer/fractional divisor, with a valid/ready divisor update taken at period boundaries.
module baud_tick_gen_frac #(
  parameter int INT_W    = 24,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int RST_INT  = 325,
  parameter int RST_FRAC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [INT_W-1:0]  i_baud_int,
  input  logic [FRAC_W-1:0] i_baud_frac,
  output logic              o_os_tick,
  output logic              o_stick,
  output logic              o_cfg_err,
  output logic [1:0]        o_dbg_state
);

  localparam int CNT_W = INT_W + 1;
  localparam int OS_W  = (OVS > 1) ? $clog2(OVS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [INT_W-1:0]    act_int_q, act_int_d;
  logic [FRAC_W-1:0]   act_frac_q, act_frac_d;
  logic [INT_W-1:0]    sh_int_q, sh_int_d;
  logic [FRAC_W-1:0]   sh_frac_q, sh_frac_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic [OS_W-1:0]     os_cnt_q, os_cnt_d;
  logic                os_tick_q, os_tick_d;
  logic                stick_q, stick_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic                xfer;
  logic                cfg_ok;
  logic                take;
  logic                boundary;
  logic                load;
  logic [INT_W-1:0]    load_int;
  logic [FRAC_W-1:0]   load_frac;
  logic [FRAC_W-1:0]   acc_base;
  logic [FRAC_W:0]     sum;

  // Handshake: a divisor transfers on a rising edge where i_cfg_valid && o_cfg_ready;
  // o_cfg_ready never depends combinationally on i_cfg_valid.
  assign xfer     = i_cfg_valid & ready_q;
  assign cfg_ok   = |i_baud_int;
  assign take     = xfer & cfg_ok;
  assign boundary = (state_q != ST_IDLE) && (cnt_q == CNT_W'(1));

  assign o_os_tick   = os_tick_q;
  assign o_stick     = stick_q;
  assign o_cfg_err   = err_q;
  assign o_cfg_ready = ready_q;
  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_en) state_d = ST_RUN;
      ST_RUN: begin
        if (!i_en)     state_d = ST_IDLE;
        else if (take) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!i_en)         state_d = ST_IDLE;
        else if (boundary) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    stick_d    = 1'b0;
    err_d      = xfer & ~cfg_ok;
    ready_d    = ready_q;
    load       = 1'b0;
    load_int   = act_int_q;
    load_frac  = act_frac_q;
    acc_base   = acc_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        acc_d    = '0;
        os_cnt_d = '0;
        ready_d  = 1'b1;
        acc_base = '0;
        if (take) begin
          act_int_d  = i_baud_int;
          act_frac_d = i_baud_frac;
          load_int   = i_baud_int;
          load_frac  = i_baud_frac;
        end
        load = i_en;
      end
      ST_RUN: begin
        if (!i_en) begin
          cnt_d    = '0;
          acc_d    = '0;
          os_cnt_d = '0;
          ready_d  = 1'b1;
          if (take) begin
            act_int_d  = i_baud_int;
            act_frac_d = i_baud_frac;
          end
        end else begin
          // A divisor taken on a boundary edge still waits for the following boundary.
          if (take) begin
            sh_int_d  = i_baud_int;
            sh_frac_d = i_baud_frac;
            ready_d   = 1'b0;
          end else begin
            ready_d = 1'b1;
          end
          if (boundary) begin
            load      = 1'b1;
            os_tick_d = 1'b1;
            stick_d   = (os_cnt_q == OS_W'(OVS - 1));
            os_cnt_d  = os_cnt_q + OS_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_PEND: begin
        if (!i_en) begin
          cnt_d      = '0;
          acc_d      = '0;
          os_cnt_d   = '0;
          ready_d    = 1'b1;
          act_int_d  = sh_int_q;
          act_frac_d = sh_frac_q;
        end else begin
          ready_d = 1'b0;
          if (boundary) begin
            // Hand-over restarts the fraction from zero but keeps the bit phase.
            load       = 1'b1;
            load_int   = sh_int_q;
            load_frac  = sh_frac_q;
            acc_base   = '0;
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
            os_tick_d  = 1'b1;
            stick_d    = (os_cnt_q == OS_W'(OVS - 1));
            os_cnt_d   = os_cnt_q + OS_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_d    = '0;
        acc_d    = '0;
        os_cnt_d = '0;
        ready_d  = 1'b1;
      end
    endcase

    sum = {1'b0, acc_base} + {1'b0, load_frac};
    if (load) begin
      acc_d = sum[FRAC_W-1:0];
      cnt_d = {1'b0, load_int} + CNT_W'(sum[FRAC_W]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_int_q  <= INT_W'(RST_INT);
      act_frac_q <= FRAC_W'(RST_FRAC);
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      stick_q    <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      stick_q    <= stick_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
`timescale 1ns/1ps
// Bench for baud_tick_gen_frac: expected tick/bit-tick edges are queued when
// stimulus is applied and popped as the DUT pulses.
module tb_baud_tick_gen_frac;

  localparam int INT_W  = 24;
  localparam int FRAC_W = 4;
  localparam int OVS    = 16;
  localparam int FMOD   = 1 << FRAC_W;

  logic              clk;
  logic              rst_n;
  logic              i_en;
  logic              i_cfg_valid;
  logic              o_cfg_ready;
  logic [INT_W-1:0]  i_baud_int;
  logic [FRAC_W-1:0] i_baud_frac;
  logic              o_os_tick;
  logic              o_stick;
  logic              o_cfg_err;
  logic [1:0]        o_dbg_state;

  baud_tick_gen_frac #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .OVS(OVS), .RST_INT(325), .RST_FRAC(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready), .i_baud_int(i_baud_int), .i_baud_frac(i_baud_frac),
    .o_os_tick(o_os_tick), .o_stick(o_stick), .o_cfg_err(o_cfg_err),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int exp_q[$];
  int stick_q[$];
  int n_err = 0;
  int n_checks = 0;
  int first_stick = -1;
  bit ready_watch = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int mon_t;
  bit mon_s;
  always @(negedge clk) begin
    if (o_os_tick) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_tick", o_os_tick, 0);
      end else begin
        mon_t = exp_q.pop_front();
        check_eq("tick_time", cyc, mon_t);
      end
      mon_s = (stick_q.size() > 0) && (stick_q[0] == cyc);
      if (mon_s) begin
        void'(stick_q.pop_front());
        if (first_stick < 0) first_stick = cyc;
      end
      check_eq("stick_on_tick", o_stick, mon_s);
      if (ready_watch) check_eq("ready_hold", o_cfg_ready, 1);
    end else if (o_stick) begin
      check_eq("stick_no_tick", o_stick, 0);
    end
  end

  // Reference model: tick edges for periods starting at e0 with acc cleared.
  task automatic plan(input int e0, input int di, input int df, input int stop, inout int os);
    int t;
    int acc;
    int sum;
    t = e0;
    acc = 0;
    while (1) begin
      sum = acc + df;
      acc = sum % FMOD;
      t = t + di + sum / FMOD;
      if (t >= stop) break;
      exp_q.push_back(t);
      if (os == OVS - 1) stick_q.push_back(t);
      os = (os + 1) % OVS;
    end
  endtask

  // Driver tasks
  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic offer(input int bi, input int bf);
    i_cfg_valid = 1'b1;
    i_baud_int  = INT_W'(bi);
    i_baud_frac = FRAC_W'(bf);
    @(negedge clk);
    i_cfg_valid = 1'b0;
  endtask

  task automatic enable(output int e0);
    i_en = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic disable_at(input int d);
    wait_until(d - 1);
    i_en = 1'b0;
    wait_until(d);
    check_eq("dis_tick", o_os_tick, 0);
    check_eq("dis_state", o_dbg_state, 0);
  endtask

  task automatic drain_check();
    repeat (3) @(negedge clk);
    check_eq("tick_q_left", exp_q.size(), 0);
    check_eq("stick_q_left", stick_q.size(), 0);
    exp_q.delete();
    stick_q.delete();
  endtask

  int e0;
  int e1;
  int os;

  initial begin
    rst_n = 1'b0;
    i_en = 1'b0;
    i_cfg_valid = 1'b0;
    i_baud_int = '0;
    i_baud_frac = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", o_cfg_ready, 1);
    check_eq("rst_tick", o_os_tick, 0);
    check_eq("rst_stick", o_stick, 0);
    check_eq("rst_err", o_cfg_err, 0);
    check_eq("rst_state", o_dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset divisor 325/0
    ready_watch = 1'b1;
    first_stick = -1;
    os = 0;
    enable(e0);
    plan(e0, 325, 0, e0 + 17 * 325 + 5, os);
    disable_at(e0 + 17 * 325 + 5);
    ready_watch = 1'b0;
    check_eq("s1_first_stick", first_stick, e0 + 5200);
    drain_check();

    // 10 + 8/16, with a rejected zero divisor mid-run
    check_eq("idle_ready", o_cfg_ready, 1);
    offer(10, 8);
    check_eq("idle_cfg_err", o_cfg_err, 0);
    check_eq("idle_cfg_state", o_dbg_state, 0);
    @(negedge clk);
    first_stick = -1;
    os = 0;
    enable(e0);
    plan(e0, 10, 8, e0 + 205, os);
    wait_until(e0 + 54);
    offer(0, 3);
    check_eq("rej_err", o_cfg_err, 1);
    check_eq("rej_ready", o_cfg_ready, 1);
    check_eq("rej_state", o_dbg_state, 1);
    @(negedge clk);
    check_eq("rej_err_pulse", o_cfg_err, 0);
    disable_at(e0 + 205);
    check_eq("s2_first_stick", first_stick, e0 + 168);
    drain_check();

    // Re-enable after a mid-period disable restarts timing from zero
    os = 0;
    enable(e1);
    plan(e1, 10, 8, e1 + 60, os);
    disable_at(e1 + 60);
    drain_check();

    // Running at 20, switch to 5 mid-period
    offer(20, 0);
    @(negedge clk);
    first_stick = -1;
    os = 0;
    enable(e0);
    plan(e0, 20, 0, e0 + 61, os);
    plan(e0 + 60, 5, 0, e0 + 200, os);
    wait_until(e0 + 49);
    check_eq("hs_ready_before", o_cfg_ready, 1);
    i_cfg_valid = 1'b1;
    i_baud_int = INT_W'(5);
    i_baud_frac = '0;
    wait_until(e0 + 50);
    i_cfg_valid = 1'b0;
    check_eq("hs_ready_drop", o_cfg_ready, 0);
    check_eq("hs_state_pend", o_dbg_state, 2);
    wait_until(e0 + 59);
    check_eq("hs_ready_wait", o_cfg_ready, 0);
    wait_until(e0 + 60);
    check_eq("hs_state_run", o_dbg_state, 1);
    wait_until(e0 + 61);
    check_eq("hs_ready_back", o_cfg_ready, 1);
    disable_at(e0 + 200);
    check_eq("s4_first_stick", first_stick, e0 + 125);
    drain_check();

    // int=1: tick every cycle, then asynchronous reset mid-run
    offer(1, 0);
    @(negedge clk);
    first_stick = -1;
    os = 0;
    enable(e0);
    plan(e0, 1, 0, e0 + 41, os);
    wait_until(e0 + 40);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tick", o_os_tick, 0);
    check_eq("arst_stick", o_stick, 0);
    check_eq("arst_ready", o_cfg_ready, 1);
    check_eq("arst_state", o_dbg_state, 0);
    check_eq("s3_first_stick", first_stick, e0 + 16);
    i_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain_check();

    // After reset the divisor is back to 325
    os = 0;
    enable(e1);
    plan(e1, 325, 0, e1 + 700, os);
    disable_at(e1 + 700);
    drain_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
